// File: rtl/hdp_pkg.sv
// Shared HDP-1280-2 definitions: register map, command-byte layout and the
// sequencer state/phase encodings.
package hdp_pkg;

  localparam int RD_BIT = 7;

  localparam logic [6:0] REG_PWR_CTRL   = 7'h01;
  localparam logic [6:0] REG_DRV_MODE   = 7'h02;
  localparam logic [6:0] REG_GAMMA_SEL  = 7'h03;
  localparam logic [6:0] REG_VCOM_TRIM  = 7'h04;
  localparam logic [6:0] REG_TIMING     = 7'h05;
  localparam logic [6:0] REG_PANEL_CFG  = 7'h06;
  localparam logic [6:0] REG_LUT_CTRL   = 7'h07;
  localparam logic [6:0] REG_TEMP_COMP  = 7'h08;
  localparam logic [6:0] REG_VDD_TRIM   = 7'h09;
  localparam logic [6:0] REG_FRAME_RATE = 7'h0A;
  localparam logic [6:0] REG_SCAN_DIR   = 7'h0B;
  localparam logic [6:0] REG_ILLUM      = 7'h0C;
  localparam logic [6:0] REG_FLICKER    = 7'h0D;
  localparam logic [6:0] REG_DITHER     = 7'h0E;
  localparam logic [6:0] REG_TEST_MODE  = 7'h0F;

  localparam logic [3:0] S_RST_HOLD     = 4'd0;
  localparam logic [3:0] S_INIT_ISSUE   = 4'd1;
  localparam logic [3:0] S_VERIFY_ISSUE = 4'd2;
  localparam logic [3:0] S_WAIT_DONE    = 4'd3;
  localparam logic [3:0] S_WAIT_IDLE    = 4'd4;
  localparam logic [3:0] S_COMPARE      = 4'd5;
  localparam logic [3:0] S_IDLE         = 4'd6;
  localparam logic [3:0] S_HOST_ISSUE   = 4'd7;
  localparam logic [3:0] S_HOST_ACK     = 4'd8;
  localparam logic [3:0] S_RECOVER      = 4'd9;

  // Which kind of transaction the shared WAIT_DONE/WAIT_IDLE states belong to.
  localparam logic [1:0] PH_WRITE  = 2'd0;
  localparam logic [1:0] PH_VERIFY = 2'd1;
  localparam logic [1:0] PH_HOST   = 2'd2;

  function automatic logic [7:0] cmd_byte(input logic rd, input logic [6:0] addr);
    logic [7:0] b;
    b         = {1'b0, addr};
    b[RD_BIT] = rd;
    return b;
  endfunction

endpackage

// File: rtl/hdp_init_rom.sv
// Power-up register table for the SLM driver: {addr, data} per entry, purely
// combinational; indices at or beyond INIT_LEN read as zero.
module hdp_init_rom
  import hdp_pkg::*;
#(
  parameter int INIT_LEN = 16
) (
  input  logic [5:0] index,
  output logic [6:0] addr,
  output logic [7:0] data
);

  logic [14:0] entry;

  always_comb begin
    entry = 15'h0;
    if (int'(index) < INIT_LEN) begin
      case (index)
        6'd0:    entry = {REG_PWR_CTRL,   8'h3C};
        6'd1:    entry = {REG_DRV_MODE,   8'h81};
        6'd2:    entry = {REG_GAMMA_SEL,  8'h5A};
        6'd3:    entry = {REG_VCOM_TRIM,  8'h0F};
        6'd4:    entry = {REG_TIMING,     8'h44};
        6'd5:    entry = {REG_PANEL_CFG,  8'h12};
        6'd6:    entry = {REG_LUT_CTRL,   8'h01};
        6'd7:    entry = {REG_TEMP_COMP,  8'h9B};
        6'd8:    entry = {REG_VDD_TRIM,   8'h27};
        6'd9:    entry = {REG_FRAME_RATE, 8'h3C};
        6'd10:   entry = {REG_SCAN_DIR,   8'h02};
        6'd11:   entry = {REG_ILLUM,      8'h80};
        6'd12:   entry = {REG_FLICKER,    8'h00};
        6'd13:   entry = {REG_DITHER,     8'h11};
        6'd14:   entry = {REG_TEST_MODE,  8'h00};
        6'd15:   entry = {REG_PWR_CTRL,   8'h3D};
        default: entry = 15'h0;
      endcase
    end
  end

  assign addr = entry[14:8];
  assign data = entry[7:0];

endmodule

// File: rtl/hdp_spi_sequencer.sv
// Owns the HDP spi engine: runs the init table (optional read-back, retries), then
// serves host single-register requests one at a time; a watchdog resets a hung engine.
module hdp_spi_sequencer
  import hdp_pkg::*;
#(
  parameter int INIT_LEN    = 16,
  parameter int VERIFY_INIT = 1,
  parameter int TIMEOUT     = 4095,
  parameter int MAX_RETRY   = 2
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       host_req,
  input  logic       host_rw,
  input  logic [6:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic       host_ack,
  output logic [7:0] host_rdata,
  output logic       host_err,
  output logic       init_done,
  output logic       init_error,
  output logic       spi_enable,
  output logic       spi_reset,
  output logic       spi_start,
  output logic       spi_multi,
  output logic [7:0] spi_tx_upper,
  output logic [7:0] spi_tx_lower,
  input  logic       spi_busy,
  input  logic       spi_done,
  input  logic [7:0] spi_rx_lower
);

  localparam int         TW         = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int         RW         = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [5:0] LAST_ENTRY = 6'(INIT_LEN - 1);

  logic [3:0]    state, state_nx;
  logic [1:0]    phase;
  logic [2:0]    cnt;
  logic          armed;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry;
  logic [5:0]    entry;
  logic [7:0]    rx_cap;
  logic          req_rw;
  logic [6:0]    req_addr;
  logic [7:0]    req_wdata;
  logic [6:0]    rom_addr;
  logic [7:0]    rom_data;
  logic          timeout, last_entry, exhausted, advance, fail;

  hdp_init_rom #(.INIT_LEN(INIT_LEN)) u_rom (
    .index (entry),
    .addr  (rom_addr),
    .data  (rom_data)
  );

  assign spi_multi  = 1'b0;
  assign timeout    = (timer == TW'(TIMEOUT));
  assign last_entry = (entry == LAST_ENTRY);
  assign exhausted  = (retry == RW'(MAX_RETRY));

  always_comb begin
    state_nx = state;
    advance  = 1'b0;
    fail     = 1'b0;
    case (state)
      S_RST_HOLD:   if (cnt == 3'd3) state_nx = S_INIT_ISSUE;
      S_INIT_ISSUE, S_VERIFY_ISSUE, S_HOST_ISSUE:
        if (armed && !spi_busy) state_nx = S_WAIT_DONE;
      // spi_done takes priority over a coincident watchdog expiry
      S_WAIT_DONE: begin
        if (spi_done)     state_nx = S_WAIT_IDLE;
        else if (timeout) state_nx = S_RECOVER;
      end
      S_WAIT_IDLE: begin
        if (!spi_busy) begin
          case (phase)
            PH_WRITE:  if (VERIFY_INIT != 0) state_nx = S_VERIFY_ISSUE;
                       else advance = 1'b1;
            PH_VERIFY: state_nx = S_COMPARE;
            default:   state_nx = S_HOST_ACK;
          endcase
        end else if (timeout) begin
          state_nx = S_RECOVER;
        end
      end
      S_COMPARE: begin
        if (rx_cap == rom_data) advance = 1'b1;
        else                    fail    = 1'b1;
      end
      S_RECOVER: begin
        if (cnt == 3'd7) begin
          if (phase == PH_HOST) state_nx = S_HOST_ACK;
          else                  fail     = 1'b1;
        end
      end
      S_IDLE:     if (host_req) state_nx = S_HOST_ISSUE;
      S_HOST_ACK: state_nx = S_IDLE;
      default:    state_nx = S_RST_HOLD;
    endcase
    // A failed attempt redoes the whole entry (write and read-back) until retries run out.
    if (fail && !exhausted)   state_nx = S_INIT_ISSUE;
    else if (advance || fail) state_nx = last_entry ? S_IDLE : S_INIT_ISSUE;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state        <= S_RST_HOLD;
      phase        <= PH_WRITE;
      cnt          <= 3'd0;
      armed        <= 1'b0;
      timer        <= '0;
      retry        <= '0;
      entry        <= 6'd0;
      rx_cap       <= 8'h00;
      req_rw       <= 1'b0;
      req_addr     <= 7'h00;
      req_wdata    <= 8'h00;
      host_ack     <= 1'b0;
      host_rdata   <= 8'h00;
      host_err     <= 1'b0;
      init_done    <= 1'b0;
      init_error   <= 1'b0;
      spi_enable   <= 1'b0;
      spi_reset    <= 1'b1;
      spi_start    <= 1'b0;
      spi_tx_upper <= 8'h00;
      spi_tx_lower <= 8'h00;
    end else begin
      state     <= state_nx;
      spi_start <= 1'b0;
      host_ack  <= 1'b0;
      host_err  <= 1'b0;
      case (state)
        S_RST_HOLD, S_RECOVER: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'd3) begin
            spi_reset  <= 1'b0;
            spi_enable <= 1'b1;
          end
        end
        // First cycle sets up the tx bytes, start follows once the engine is idle.
        S_INIT_ISSUE, S_VERIFY_ISSUE, S_HOST_ISSUE: begin
          if (!armed) begin
            armed <= 1'b1;
            if (state == S_INIT_ISSUE) begin
              spi_tx_upper <= cmd_byte(1'b0, rom_addr);
              spi_tx_lower <= rom_data;
              phase        <= PH_WRITE;
            end else if (state == S_VERIFY_ISSUE) begin
              spi_tx_upper <= cmd_byte(1'b1, rom_addr);
              spi_tx_lower <= 8'h00;
              phase        <= PH_VERIFY;
            end else begin
              spi_tx_upper <= cmd_byte(req_rw, req_addr);
              spi_tx_lower <= req_rw ? 8'h00 : req_wdata;
              phase        <= PH_HOST;
            end
          end else if (!spi_busy) begin
            spi_start <= 1'b1;
            timer     <= '0;
            armed     <= 1'b0;
          end
        end
        S_WAIT_DONE, S_WAIT_IDLE: begin
          timer <= timer + 1'b1;
          if (state == S_WAIT_IDLE && !spi_busy) rx_cap <= spi_rx_lower;
        end
        S_IDLE: begin
          if (host_req) begin
            req_rw    <= host_rw;
            req_addr  <= host_addr;
            req_wdata <= host_wdata;
          end
        end
        default: ;
      endcase

      if (state != S_RECOVER && state_nx == S_RECOVER) begin
        cnt        <= 3'd0;
        spi_reset  <= 1'b1;
        spi_enable <= 1'b0;
      end

      if (state != S_HOST_ACK && state_nx == S_HOST_ACK) begin
        host_ack   <= 1'b1;
        host_err   <= (state == S_RECOVER);
        host_rdata <= (state == S_RECOVER || !req_rw) ? 8'h00 : spi_rx_lower;
      end

      if (fail && !exhausted) retry <= retry + RW'(1);
      if (advance || (fail && exhausted)) begin
        retry <= '0;
        if (fail) init_error <= 1'b1;
        if (last_entry) init_done <= 1'b1;
        else            entry     <= entry + 6'd1;
      end
    end
  end

endmodule

// File: doc/hdp_spi_sequencer.md
# hdp_spi_sequencer

Controller that owns the HDP-1280-2 `spi` block and sequences all register traffic to the SLM driver IC. After reset it runs a fixed initialisation table of register writes, each optionally read back and compared. It then arbitrates single-register read/write requests from the host logic onto the same SPI engine. It supervises every transaction with a watchdog and recovers the SPI engine on a hang.

## Interface
Parameters:
- INIT_LEN, 16: number of entries in the init table (1..64).
- VERIFY_INIT, 1: when 1, each init write is followed by a read-back compare.
- TIMEOUT, 4095: i_clock cycles allowed per SPI transaction before abort.
- MAX_RETRY, 2: retries per init entry on timeout or compare mismatch.

Ports:
- i_clock  in  1  system clock (66 MHz).
- i_reset  in  1  reset; asynchronous, active-high.
- host_req  in  1  level request; held until host_ack.
- host_rw  in  1  1 = read, 0 = write.
- host_addr  in  7  HDP register address.
- host_wdata  in  8  write data.
- host_ack  out  1  one-cycle pulse when the request has completed.
- host_rdata  out  8  read data; valid with host_ack when host_rw = 1.
- host_err  out  1  one-cycle pulse with host_ack if the transaction timed out.
- init_done  out  1  sticky; init table finished (pass or fail).
- init_error  out  1  sticky; some entry exhausted its retries.
- spi_enable  out  1  enable to `spi`.
- spi_reset  out  1  reset to `spi`.
- spi_start  out  1  start_transfer to `spi`.
- spi_multi  out  1  multi_byte_spi_trans_flag; tied 0.
- spi_tx_upper  out  8  {rw, addr[6:0]}; rw = 1 for read.
- spi_tx_lower  out  8  write data, 0x00 for reads.
- spi_busy  in  1  busy from `spi`.
- spi_done  in  1  o_transaction_complete from `spi` (one-cycle pulse).
- spi_rx_lower  in  8  Rx_Lower_Byte from `spi`.

## Operation
- Reset values: all outputs 0, except spi_reset = 1. Entry index, retry count and timer are 0.
- States: RST_HOLD → INIT_ISSUE → WAIT_DONE → WAIT_IDLE → (VERIFY_ISSUE → WAIT_DONE → WAIT_IDLE → COMPARE) → next entry … → IDLE → HOST_ISSUE → WAIT_DONE → WAIT_IDLE → HOST_ACK → IDLE. Abort states: RECOVER → back to the issuing state.
- RST_HOLD: spi_reset is held for 4 cycles after i_reset deasserts. spi_enable rises when spi_reset falls.
- Issue states: spi_tx_upper and spi_tx_lower are driven first. spi_start pulses high for 1 cycle only if spi_busy = 0; otherwise the block waits. The tx outputs stay stable until WAIT_IDLE exits.
- WAIT_DONE exits on spi_done. WAIT_IDLE exits when spi_busy = 0. spi_rx_lower is captured on the WAIT_IDLE exit.
- COMPARE: if captured data equals the table data, advance to the next entry. Otherwise retry the whole entry, i.e. the write and the read.
- Retry: when the retry count reaches MAX_RETRY, set init_error, skip the entry and reset the count.
- After entry INIT_LEN−1, set init_done and go to IDLE.
- Host requests are ignored (no ack) until init_done. From IDLE, host_req is sampled once and host_addr/wdata/rw are latched. host_ack pulses 1 cycle in HOST_ACK, and host_rdata is updated in the same cycle. Retries never apply to host requests.
- Watchdog: the timer clears on each spi_start and counts in WAIT_DONE and WAIT_IDLE. At TIMEOUT the block enters RECOVER: spi_reset = 1 for 4 cycles, then 4 idle cycles. An init transaction counts as a failed attempt. A host transaction acks with host_err = 1 and host_rdata = 0x00.
- Mid-operation i_reset: immediately returns every output to its reset value and restarts the init table from entry 0.

## Timing
- spi_clk period is 68 i_clock. One SPI transaction is about 20 spi_clk ≈ 1400 cycles, so TIMEOUT = 4095 gives about 3× margin.
- Minimum gap between spi_start pulses is spi_busy low plus 1 cycle, which guarantees `spi` re-arms its edge detector.
- Host latency is about 1 transaction plus 4 cycles from sampling host_req to host_ack. A new request is sampled no earlier than 1 cycle after host_ack.
- Simultaneous spi_done and timer expiry: spi_done wins.

## Structure
- Shared package `hdp_pkg`: HDP register address constants, the read flag bit position (bit 7), and the state enum encoding.
- Sub-module `hdp_init_rom`: combinational {addr[6:0], data[7:0]} lookup indexed by a 6-bit entry index, holding INIT_LEN entries.

## Test plan
- Reset release with a SPI slave model echoing writes, INIT_LEN = 4: 4 writes and 4 reads appear on MOSI with first byte {0, addr}. Then init_done = 1 and init_error = 0.
- Slave returns 0xFF for entry 2's read-back: entry 2 is attempted exactly 3 times in total. Then init_error = 1, entries 3.. continue, and init_done = 1.
- After init, host read of addr 0x05 with slave returning 0xA5: first byte 0x85, then host_ack pulses for 1 cycle with host_rdata = 0xA5 and host_err = 0.
- Slave model that suppresses spi_done: after 4095 cycles spi_reset pulses for 4 cycles, then host_ack pulses with host_err = 1 and host_rdata = 0x00.
- host_req asserted before init_done: no ack until init completes, then it is served once.
- i_reset asserted mid-transaction: all outputs return to reset values, spi_reset = 1, and init restarts at entry 0.
